msdap_out_serializer: RTL and testbench
=======================================

// Module: msdap_out_serializer
// PURPOSE
//  Output stage of MSDAP. Accepts 40-bit left/right filter results from the
//  convolution datapath over a valid/ready handshake and buffers them in a
//  DEPTH-entry FIFO. Shifts each L/R pair out MSB-first on OutputL/OutputR,
//  one bit per SCLK, with OutReady high for exactly WIDTH cycles per word.
//  Back-to-back words stream with no idle gap.
// PARAMETERS
//  WIDTH  40  result word width; serial length per word
//  DEPTH  4   FIFO entries (L/R pairs); power of 2, >= 2
// PORTS
//  SCLK      in   1      system clock; all logic on posedge
//  Reset     in   1      synchronous, active-high reset
//  Start     in   1      synchronous flush: abort current word, empty FIFO
//  InL_data  in   WIDTH  left result from datapath
//  InR_data  in   WIDTH  right result from datapath
//  In_valid  in   1      InL_data/InR_data valid this cycle
//  In_ready  out  1      FIFO can accept a pair (= !full)
//  OutputL   out  1      left serial bit, MSB first
//  OutputR   out  1      right serial bit, MSB first
//  OutReady  out  1      OutputL/R carry a valid bit this cycle
//  Busy      out  1      shifter active or FIFO non-empty
// BEHAVIOUR
//  - One clock (SCLK). Reset is synchronous, active-high. Reset wins over
//    Start. Start wins over In_valid: a push in a Start cycle is dropped.
//  - Reset/Start response, from the next edge on: OutReady=0, OutputL=0,
//    OutputR=0, In_ready=1, Busy=0, FIFO empty, state=IDLE, bit_cnt=0.
//  - Push: on an edge with In_valid && In_ready. In_ready = !full, computed
//    from the registered count. A push is refused when full, even if a pop
//    occurs in the same cycle.
//  - FSM IDLE: if FIFO is non-empty, pop the head into shL/shR at the edge,
//    then bit_cnt=0 and state=SHIFT.
//  - FSM SHIFT: OutReady=1, OutputL=shL[WIDTH-1], OutputR=shR[WIDTH-1].
//    Each edge shifts left by one and increments bit_cnt.
//  - End of word: on the edge where bit_cnt==WIDTH-1:
//    - FIFO non-empty: pop and load the next pair, bit_cnt=0, stay in SHIFT.
//      No gap between words.
//    - FIFO empty: go to IDLE; OutReady=0 and outputs=0 from the next edge.
//  - Outputs are registered. They change only on posedge SCLK.
//  - Latency: pair pushed at edge e into an empty, idle block gives MSB on
//    OutputL/R with OutReady=1 after edge e+2.
//  - Consumer samples on the edge after presentation.
//  - Simultaneous push and pop when not full: both occur; count unchanged.
//  - FIFO pointers wrap modulo DEPTH. Count has log2(DEPTH)+1 bits.
//  - No arithmetic on data; words pass bit-exact.
//  - Mid-word Reset or Start discards the remaining bits of the current word.
// CONFIGURATION
//  MSDAP_OUT_FRAME_EN defined:
//  - Adds output port OutFrame (1 bit), registered.
//  - OutFrame=1 exactly in the cycle presenting bit WIDTH-1 (MSB) of each
//    word; 0 otherwise, including after reset and flush.
//  MSDAP_OUT_FRAME_EN undefined:
//  - Port and logic are absent; all other behaviour is identical.
// TESTING
//  1. Reset=1 for 1 cycle -> OutReady=0, OutputL/R=0, In_ready=1, Busy=0.
//  2. Push L=40'h00_0000_0001, R=40'h80_0000_0000 ->
//     - OutReady=1 from edge e+2 for exactly 40 cycles.
//     - L stream: 39 zeros then 1. R stream: 1 then 39 zeros.
//  3. Push 40'hA5A5A5A5A5, 40'h5A5A5A5A5A, 40'hFFFFFFFFFF on 3 consecutive
//     cycles (R = ~L) -> OutReady high 120 contiguous cycles; bits in order.
//  4. Push 6 pairs with In_valid held (DEPTH=4) ->
//     - In_ready drops after the 5th accept.
//     - 6th is accepted at the first word boundary.
//     - All 6 emerge in order; 240 contiguous OutReady cycles.
//  5. Start=1 at bit 20 of a word with 2 queued ->
//     - OutReady=0 and outputs=0 next cycle; Busy=0.
//     - A later push is sent whole (40 bits).
//  6. MSDAP_OUT_FRAME_EN build, scenario 3 -> OutFrame pulses at cycles
//     0, 40 and 80 of the burst only; Reset mid-word behaves as item 5.

Source files
------------

// File: rtl/msdap_out_serializer.sv
// msdap_out_serializer
//   Output stage of MSDAP. Left/right result pairs arrive over a valid/ready
//   handshake into a DEPTH-entry FIFO. Each pair is shifted out MSB-first on
//   OutputL/OutputR, one bit per SCLK. OutReady is high for exactly WIDTH
//   cycles per word. Back-to-back words stream with no idle cycle between them.
//
//   Parameters: WIDTH (word / serial length), DEPTH (FIFO pairs, power of 2, >= 2)
//   Ports:
//     SCLK      in   clock, all logic on posedge
//     Reset     in   synchronous active-high reset (wins over Start)
//     Start     in   synchronous flush: abort current word, empty FIFO
//     InL_data  in   left result word
//     InR_data  in   right result word
//     In_valid  in   pair valid this cycle
//     In_ready  out  FIFO not full
//     OutputL   out  left serial bit (registered)
//     OutputR   out  right serial bit (registered)
//     OutReady  out  OutputL/R valid this cycle (registered)
//     Busy      out  serialisation in progress or FIFO non-empty
//     OutFrame  out  only when MSDAP_OUT_FRAME_EN is defined: high while the
//                    MSB of a word is presented
module msdap_out_serializer #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 4
) (
  input  logic             SCLK,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] InL_data,
  input  logic [WIDTH-1:0] InR_data,
  input  logic             In_valid,
  output logic             In_ready,
  output logic             OutputL,
  output logic             OutputR,
  output logic             OutReady,
  output logic             Busy
`ifdef MSDAP_OUT_FRAME_EN
  ,
  output logic             OutFrame
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t state, next_state;

  logic [WIDTH-1:0] mem_l [DEPTH];
  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] sh_l, sh_r;
  logic [BW-1:0]    bit_cnt;

  logic full, empty, word_end, push, pop, clear;

  assign clear    = Reset || Start;
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign In_ready = !full;
  assign Busy     = (state == SHIFT) || !empty || OutReady;

  // FSM next state and handshake decisions
  always_comb begin
    next_state = state;
    word_end   = 1'b0;
    pop        = 1'b0;
    push       = In_valid && !full && !clear;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          next_state = SHIFT;
        end
      end
      SHIFT: begin
        word_end = (bit_cnt == LAST_BIT);
        if (word_end) begin
          if (!empty) pop = 1'b1;
          else        next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
    if (clear) pop = 1'b0;
  end

  always_ff @(posedge SCLK) begin
    if (clear) state <= IDLE;
    else       state <= next_state;
  end

  // FIFO storage (data only, no reset needed)
  always_ff @(posedge SCLK) begin
    if (push) begin
      mem_l[wr_ptr] <= InL_data;
      mem_r[wr_ptr] <= InR_data;
    end
  end

  always_ff @(posedge SCLK) begin
    if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // Shifter. The output register samples the shifter MSB on the same edge
  // the shifter advances, so the serial stream trails the shifter by one
  // cycle and a load at a word boundary lands with no gap.
  always_ff @(posedge SCLK) begin
    if (clear) begin
      sh_l    <= '0;
      sh_r    <= '0;
      bit_cnt <= '0;
    end else if (pop) begin
      sh_l    <= mem_l[rd_ptr];
      sh_r    <= mem_r[rd_ptr];
      bit_cnt <= '0;
    end else if (state == SHIFT) begin
      sh_l    <= {sh_l[WIDTH-2:0], 1'b0};
      sh_r    <= {sh_r[WIDTH-2:0], 1'b0};
      bit_cnt <= word_end ? '0 : bit_cnt + BW'(1);
    end
  end

  always_ff @(posedge SCLK) begin
    if (clear) begin
      OutReady <= 1'b0;
      OutputL  <= 1'b0;
      OutputR  <= 1'b0;
    end else begin
      OutReady <= (state == SHIFT);
      OutputL  <= (state == SHIFT) && sh_l[WIDTH-1];
      OutputR  <= (state == SHIFT) && sh_r[WIDTH-1];
    end
  end

`ifdef MSDAP_OUT_FRAME_EN
  always_ff @(posedge SCLK) begin
    if (clear) OutFrame <= 1'b0;
    else       OutFrame <= (state == SHIFT) && (bit_cnt == '0);
  end
`endif

endmodule

// File: tb/tb_msdap_out_serializer.sv
// Directed testbench for msdap_out_serializer (WIDTH=40, DEPTH=4).
// Build with MSDAP_OUT_FRAME_EN defined to also check OutFrame.
module tb_msdap_out_serializer;

  localparam int W = 40;

  logic         clk = 1'b0;
  logic         rst, start, in_valid;
  logic [W-1:0] in_l, in_r;
  logic         in_ready, out_l, out_r, out_ready, busy;
`ifdef MSDAP_OUT_FRAME_EN
  logic         out_frame;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  // serial capture, recorded on the falling edge
  logic cap_l[$];
  logic cap_r[$];
  logic cap_f[$];
  int   runs[$];
  int   run = 0;

  always #5 clk = ~clk;

  msdap_out_serializer #(.WIDTH(W), .DEPTH(4)) dut (
    .SCLK     (clk),
    .Reset    (rst),
    .Start    (start),
    .InL_data (in_l),
    .InR_data (in_r),
    .In_valid (in_valid),
    .In_ready (in_ready),
    .OutputL  (out_l),
    .OutputR  (out_r),
    .OutReady (out_ready),
    .Busy     (busy)
`ifdef MSDAP_OUT_FRAME_EN
    ,
    .OutFrame (out_frame)
`endif
  );

  always @(negedge clk) begin
    if (out_ready) begin
      cap_l.push_back(out_l);
      cap_r.push_back(out_r);
`ifdef MSDAP_OUT_FRAME_EN
      cap_f.push_back(out_frame);
`else
      cap_f.push_back(1'b0);
`endif
      run++;
    end else if (run != 0) begin
      runs.push_back(run);
      run = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_capture();
    cap_l.delete();
    cap_r.delete();
    cap_f.delete();
    runs.delete();
  endtask

  task automatic wait_idle(input int budget);
    int b = 0;
    while (busy && b < budget) begin
      tick();
      b++;
    end
    check("idle_timeout", {63'd0, busy}, 64'd0);
    tick();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_outready"}, {63'd0, out_ready}, 64'd0);
    check({tag, "_outl"},     {63'd0, out_l},     64'd0);
    check({tag, "_outr"},     {63'd0, out_r},     64'd0);
    check({tag, "_inready"},  {63'd0, in_ready},  64'd1);
    check({tag, "_busy"},     {63'd0, busy},      64'd0);
`ifdef MSDAP_OUT_FRAME_EN
    check({tag, "_frame"},    {63'd0, out_frame}, 64'd0);
`endif
  endtask

  // compare captured word idx against expected L/R and frame pattern
  task automatic check_word(input string tag, input int idx,
                            input logic [W-1:0] el, input logic [W-1:0] er);
    logic [W-1:0] wl, wr, wf;
    wl = '0; wr = '0; wf = '0;
    for (int i = 0; i < W; i++) begin
      if (idx * W + i < cap_l.size()) begin
        wl = {wl[W-2:0], cap_l[idx*W+i]};
        wr = {wr[W-2:0], cap_r[idx*W+i]};
        wf = {wf[W-2:0], cap_f[idx*W+i]};
      end
    end
    check({tag, "_L"}, {24'd0, wl}, {24'd0, el});
    check({tag, "_R"}, {24'd0, wr}, {24'd0, er});
`ifdef MSDAP_OUT_FRAME_EN
    check({tag, "_frame"}, {24'd0, wf}, 64'h80_0000_0000);
`endif
  endtask

  logic [W-1:0] t3_l [3] = '{40'hA5A5A5A5A5, 40'h5A5A5A5A5A, 40'hFFFFFFFFFF};
  logic [W-1:0] t4_l [6] = '{40'h1234567890, 40'hFEDCBA9876, 40'h8000000001,
                             40'h00FF00FF00, 40'hC3C3C3C3C3, 40'h0F0F0F0F0F};
  logic [W-1:0] t4_r [6] = '{40'h0987654321, 40'h0123456789, 40'h7FFFFFFFFE,
                             40'hFF00FF00FF, 40'h3C3C3C3C3C, 40'hF0F0F0F0F0};

  initial begin
    logic [W-1:0] el, er;
    int b;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_l = '0; in_r = '0;

    // 1: reset
    tick();
    rst = 1'b0;
    check_idle_outputs("reset");

    // 2: single word, latency and bit order
    el = 40'h00_0000_0001; er = 40'h80_0000_0000;
    in_l = el; in_r = er; in_valid = 1'b1;
    tick();                                   // edge e
    in_valid = 1'b0;
    check("lat_e0", {63'd0, out_ready}, 64'd0);
    tick();                                   // edge e+1
    check("lat_e1", {63'd0, out_ready}, 64'd0);
    tick();                                   // edge e+2: MSB presented
    for (int i = 0; i < W; i++) begin
      check("w2_ready", {63'd0, out_ready}, 64'd1);
      check("w2_L", {63'd0, out_l}, {63'd0, (i == W - 1)});
      check("w2_R", {63'd0, out_r}, {63'd0, (i == 0)});
`ifdef MSDAP_OUT_FRAME_EN
      check("w2_frame", {63'd0, out_frame}, {63'd0, (i == 0)});
`endif
      tick();
    end
    check("w2_end_ready", {63'd0, out_ready}, 64'd0);
    check("w2_end_L", {63'd0, out_l}, 64'd0);
    check("w2_end_R", {63'd0, out_r}, 64'd0);
    check("w2_end_busy", {63'd0, busy}, 64'd0);
    tick();
    clear_capture();

    // 3: three back-to-back words
    for (int k = 0; k < 3; k++) begin
      in_l = t3_l[k]; in_r = ~t3_l[k]; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    wait_idle(300);
    check("t3_runs", runs.size(), 1);
    if (runs.size() > 0) check("t3_runlen", runs[0], 120);
    for (int k = 0; k < 3; k++) check_word("t3_word", k, t3_l[k], ~t3_l[k]);
    clear_capture();

    // 4: six pairs with In_valid held, FIFO fills
    for (int k = 0; k < 5; k++) begin
      in_l = t4_l[k]; in_r = t4_r[k]; in_valid = 1'b1;
      check("t4_inready_pre", {63'd0, in_ready}, 64'd1);
      tick();
    end
    check("t4_full", {63'd0, in_ready}, 64'd0);
    in_l = t4_l[5]; in_r = t4_r[5];
    b = 0;
    while (!in_ready && b < 80) begin
      tick();
      b++;
    end
    check("t4_ready_timeout", {63'd0, in_ready}, 64'd1);
    tick();
    in_valid = 1'b0;
    wait_idle(400);
    check("t4_runs", runs.size(), 1);
    if (runs.size() > 0) check("t4_runlen", runs[0], 240);
    for (int k = 0; k < 6; k++) check_word("t4_word", k, t4_l[k], t4_r[k]);

    // 5: Start at bit 20 with two pairs queued; push in Start cycle dropped
    for (int k = 0; k < 3; k++) begin
      in_l = t4_l[k]; in_r = t4_r[k]; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    check("t5_first_bit", {63'd0, out_ready}, 64'd1);
    for (int i = 0; i < 20; i++) tick();
    check("t5_bit20_ready", {63'd0, out_ready}, 64'd1);
    start = 1'b1; in_valid = 1'b1; in_l = t4_l[3]; in_r = t4_r[3];
    tick();
    start = 1'b0; in_valid = 1'b0;
    check_idle_outputs("flush");
    tick(); tick(); tick();
    check("flush_stays_idle", {63'd0, out_ready}, 64'd0);
    clear_capture();
    el = 40'hDEADBEEF01; er = 40'h13579BDF02;
    in_l = el; in_r = er; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_idle(100);
    check("t5_runs", runs.size(), 1);
    if (runs.size() > 0) check("t5_runlen", runs[0], 40);
    check_word("t5_word", 0, el, er);

    // 6: Reset mid-word behaves as flush
    in_l = t3_l[0]; in_r = t3_l[1]; in_valid = 1'b1;
    tick();
    in_l = t3_l[2]; in_r = t3_l[0];
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle_outputs("midreset");
    tick(); tick();
    check("midreset_stays_idle", {63'd0, out_ready}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
